// File: rtl/cs_pkg.sv
// cs_pkg: shared definitions for the control sequencer.
//   - opcode constants for the 4-bit opcode field
//   - 3-bit FSM state encoding
//   - instruction field bit positions
//   - small opcode classification helpers
package cs_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field positions (imm overlaps rs2 by design)
    localparam int OP_MSB  = 23;
    localparam int OP_LSB  = 20;
    localparam int RD_MSB  = 19;
    localparam int RD_LSB  = 15;
    localparam int RS1_MSB = 14;
    localparam int RS1_LSB = 10;
    localparam int RS2_MSB = 9;
    localparam int RS2_LSB = 5;
    localparam int IMM_MSB = 9;
    localparam int IMM_LSB = 2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes that produce a register file write (ADD through MOV)
    function automatic logic is_write_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    // Opcodes B..E are undefined
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction memory handshake plus register file
// read/write ports of the sequencer.
//   master: sequencer side (drives req/addr, read addrs, write port)
//   slave : memory / register file side (drives ack/data, read data)
interface control_sequencer_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [23:0] imem_data;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [7:0]  a3;
    logic        reg_read_en;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic [7:0]  write_data;
    logic        reg_write_en;

    modport master (
        output imem_req, imem_addr, a1, a2, a3, reg_read_en, write_data, reg_write_en,
        input  imem_ack, imem_data, rd1, rd2
    );

    modport slave (
        input  imem_req, imem_addr, a1, a2, a3, reg_read_en, write_data, reg_write_en,
        output imem_ack, imem_data, rd1, rd2
    );
endinterface

// File: rtl/cs_alu.sv
// cs_alu: combinational ALU for the sequencer EXEC path.
//   op     in  4  opcode
//   a, b   in  8  latched operands (rs1, rs2)
//   imm    in  8  immediate field
//   result out 8  modulo-256 result
//   eq     out 1  a == b (BEQ condition)
module cs_alu
    import cs_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm,
    output logic [7:0] result,
    output logic       eq
);

    assign eq = (a == b);

    // Operation select; non-writing opcodes yield zero
    always_comb begin
        result = 8'h00;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = imm;
            OP_ADDI: result = a + imm;
            OP_MOV:  result = a;
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/READ/EXEC/WB sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of control_sequencer_if (imem handshake,
//                register file read addresses/enable, write port)
//   halted     : high from HALT execution until reset
//   illegal    : one-cycle pulse in EXEC for opcodes B..E
// All outputs are registers; enables are loaded from the next state so they
// line up with the state they belong to.
module control_sequencer
    import cs_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    control_sequencer_if.master       bus,
    output logic                      halted,
    output logic                      illegal
);

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  pc_r;
    // ir bits [1:0] carry no field, so they are not stored
    logic [23:2] ir_r;
    logic [7:0]  a1_r, a2_r, a3_r;
    logic [7:0]  op_a_r, op_b_r;
    logic [7:0]  result_r;
    logic        taken_r;
    logic        imem_req_r;
    logic        read_en_r;
    logic        write_en_r;
    logic        halted_r;
    logic        illegal_r;

    logic [3:0]  op_s;
    logic [7:0]  imm_s;
    logic [7:0]  alu_result_s;
    logic        alu_eq_s;

    assign op_s  = ir_r[OP_MSB:OP_LSB];
    assign imm_s = ir_r[IMM_MSB:IMM_LSB];

    cs_alu u_alu (
        .op     (op_s),
        .a      (op_a_r),
        .b      (op_b_r),
        .imm    (imm_s),
        .result (alu_result_s),
        .eq     (alu_eq_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: state_nx_s = ST_READ;
            ST_READ:   state_nx_s = ST_EXEC;
            ST_EXEC: begin
                if (op_s == OP_HALT) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            ST_WB:     state_nx_s = ST_FETCH;
            ST_HALT:   state_nx_s = ST_HALT;
            default:   state_nx_s = ST_FETCH;
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= 8'h00;
            ir_r       <= 22'h0;
            a1_r       <= 8'h00;
            a2_r       <= 8'h00;
            a3_r       <= 8'h00;
            op_a_r     <= 8'h00;
            op_b_r     <= 8'h00;
            result_r   <= 8'h00;
            taken_r    <= 1'b0;
            imem_req_r <= 1'b0;
            read_en_r  <= 1'b0;
            write_en_r <= 1'b0;
            halted_r   <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            imem_req_r <= (state_nx_s == ST_FETCH);
            read_en_r  <= (state_nx_s == ST_READ);
            write_en_r <= (state_nx_s == ST_WB) && is_write_op(op_s);
            halted_r   <= (state_nx_s == ST_HALT);
            illegal_r  <= (state_nx_s == ST_EXEC) && is_illegal_op(op_s);

            if ((state_r == ST_FETCH) && bus.imem_ack) begin
                ir_r <= bus.imem_data[23:2];
            end
            if (state_r == ST_DECODE) begin
                a1_r <= {3'b000, ir_r[RS1_MSB:RS1_LSB]};
                a2_r <= {3'b000, ir_r[RS2_MSB:RS2_LSB]};
                a3_r <= {3'b000, ir_r[RD_MSB:RD_LSB]};
            end
            // Operands are captured here, so rd==rs1 still sees the old value
            if (state_r == ST_READ) begin
                op_a_r <= bus.rd1;
                op_b_r <= bus.rd2;
            end
            if (state_r == ST_EXEC) begin
                result_r <= alu_result_s;
                taken_r  <= (op_s == OP_JMP) || ((op_s == OP_BEQ) && alu_eq_s);
            end
            if (state_r == ST_WB) begin
                pc_r <= taken_r ? imm_s : (pc_r + 8'd1);
            end
        end
    end

    assign bus.imem_req     = imem_req_r;
    assign bus.imem_addr    = pc_r;
    assign bus.a1           = a1_r;
    assign bus.a2           = a2_r;
    assign bus.a3           = a3_r;
    assign bus.reg_read_en  = read_en_r;
    assign bus.write_data   = result_r;
    assign bus.reg_write_en = write_en_r;
    assign halted           = halted_r;
    assign illegal          = illegal_r;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit microprocessor, sitting directly upstream of the register file. It fetches 24-bit instructions from instruction memory over a req/ack handshake, drives the register file read addresses and read enable, executes the operation in an internal ALU, and drives the register file write port for writeback. Branches and halt are handled here; the program counter lives here.

## Interface
- No parameters; widths fixed: data 8, PC 8, instruction 24, register address 8 (only [4:0] meaningful, [7:5] driven 0).
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request; held until acked
- imem_addr  out  8  fetch address (equals pc)
- imem_ack  in  1  instruction memory ack; imem_data valid in the same cycle
- imem_data  in  24  instruction word
- a1, a2  out  8  register file read addresses (rs1, rs2)
- a3  out  8  register file write address (rd)
- reg_read_en  out  1  register file read enable
- rd1, rd2  in  8  register file read data (combinational from a1/a2)
- write_data  out  8  writeback data
- reg_write_en  out  1  register file write enable, one-cycle pulse
- halted  out  1  high once HALT executed, until reset
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Instruction fields: op = [23:20], rd = [19:15], rs1 = [14:10], rs2 = [9:5], imm = [9:2].
- Opcodes: 0 NOP; 1 ADD rd=rs1+rs2; 2 SUB rd=rs1-rs2; 3 AND; 4 OR; 5 XOR; 6 LDI rd=imm; 7 ADDI rd=rs1+imm; 8 MOV rd=rs1; 9 BEQ if rs1==rs2 then pc=imm; A JMP pc=imm; F HALT; B–E illegal (pulse illegal, behave as NOP).
- Arithmetic modulo 256; no flags retained. SUB is two's complement wrap (3-5 = 0xFE).
- States: FETCH -> DECODE -> READ -> EXEC -> WB -> FETCH; HALT terminal.
- FETCH: imem_req=1, imem_addr=pc; on edge with imem_ack=1 latch imem_data into ir, go DECODE; otherwise stay.
- DECODE: a1/a2/a3 loaded from ir fields (zero-extended), held until next DECODE.
- READ: reg_read_en=1; rd1/rd2 latched into operand registers at end of cycle.
- EXEC: ALU result latched; branch condition evaluated; HALT goes to HALT state (pc unchanged, no WB).
- WB: reg_write_en=1 only for ops 1–8; write_data = latched result, a3 = rd. pc <= branch taken ? imm : pc+1 (255 wraps to 0). Go FETCH.
- HALT: all enables and imem_req 0, halted=1; leaves only via reset.

## Timing
- Reset (async assert): state=FETCH, pc=0, ir=0, a1=a2=a3=0, write_data=0, reg_read_en=reg_write_en=0, imem_req=0, halted=0, illegal=0. imem_req rises the first cycle after rst_n deasserts (state FETCH registered, req decoded from state).
- All outputs registered or decoded from registered state; none combinationally from imem_ack/rd1/rd2.
- Minimum 5 cycles per instruction (ack in first FETCH cycle); each wait cycle adds one.
- imem_ack ignored outside FETCH.
- illegal pulses in EXEC cycle only.
- Reset mid-WB: reg_write_en drops immediately (async), write not performed.
- rd==rs1 (e.g. ADD r1,r1,r2): operands latched in READ, so old value used; write lands at WB edge.
- Next instruction's READ sees prior WB write (regfile writes on WB edge, ≥2 cycles earlier).

## Structure
- Package cs_pkg: opcode constants, state encoding (3-bit), instruction field bit positions.
- Sub-module cs_alu: combinational op/a/b -> 8-bit result and eq flag; instantiated once in EXEC path.

## Test plan
- Reset then ack immediately: imem_req high cycle 1 with imem_addr=0; LDI r3,0x5A -> reg_write_en pulse at cycle 5, a3=3, write_data=0x5A.
- ADD r1,r2,r3 with rd1=0xF0, rd2=0x20 -> write_data=0x10, a1=2, a2=3, a3=1; SUB 3-5 -> 0xFE.
- Ack delayed 3 cycles -> instruction takes 8 cycles, imem_req held steady, pc unchanged until WB.
- BEQ with rd1=rd2=7, imm=0x40 -> next imem_addr=0x40, no write; unequal -> pc+1; pc=0xFF NOP -> next fetch 0x00.
- Opcode 0xC -> illegal one-cycle pulse in EXEC, no write, pc+1; HALT -> halted=1, imem_req stays 0 for 20 cycles.
- rst_n low during WB -> reg_write_en 0 same cycle, pc=0, restart fetch from 0 after release.
